imem_line_fill_responder: RTL and testbench
===========================================

# imem_line_fill_responder

Memory-side responder for the instruction cache's wide line-fill request interface. It accepts a line request on `mem_req_valid`/`mem_req_addr` and reads the line one 32-bit word at a time from a narrow synchronous instruction SRAM. It assembles the words into a full cache line and returns the line on `mem_req_rdata` with a single-cycle `mem_req_ready` pulse. It sits between the compressed-code icache and the word-wide program memory.

## Interface
Parameters:
- `NUM_BLOCKS`, default 4: words per cache line; power of two, at least 2.
- `BLOCK_SIZE`, default 4: bytes per word; fixed at 4 (word path is 32 bits).
- `EXTRA_LATENCY`, default 0: additional wait cycles inserted after assembly and before `mem_req_ready`; 0..255.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `mem_req_valid`, in, 1: line request from the cache.
- `mem_req_addr`, in, 32: byte address of the request; low log2(NUM_BLOCKS*4) bits are ignored.
- `mem_req_ready`, out, 1: one-cycle pulse; `mem_req_rdata` is valid in that cycle.
- `mem_req_rdata`, out, 32*NUM_BLOCKS: assembled line; word k occupies bits [32k +: 32].
- `sram_en`, out, 1: SRAM read enable.
- `sram_addr`, out, 32: SRAM byte address, word-aligned.
- `sram_rdata`, in, 32: SRAM read data, valid the cycle after `sram_en` is sampled.
- `fill_count`, out, 32: number of completed responses; wraps modulo 2^32.

## Operation
- States: IDLE, READ, DELAY, RESP, DRAIN. All outputs are registered.
- IDLE:
  - When `mem_req_valid` is 1: latch base = addr with the line-offset bits cleared.
  - Drive `sram_en`=1 and `sram_addr`=base.
  - Clear the issue and capture counters, clear the abort flag, go to READ.
- READ:
  - Issue words 1..NUM_BLOCKS-1 on consecutive cycles: `sram_addr` = base+4k, with `sram_en` held at 1 through the last issue and then 0.
  - Capture `sram_rdata` into line word j on each cycle following an issued read, with j incrementing.
  - After word NUM_BLOCKS-1 is captured: go to DELAY if EXTRA_LATENCY>0, otherwise go to RESP.
- DELAY: count EXTRA_LATENCY cycles, then go to RESP.
- RESP:
  - If the abort flag is clear: `mem_req_ready`=1 for exactly one cycle, and `fill_count` increments.
  - If the abort flag is set: no pulse and no increment.
  - Either way, go to DRAIN.
- DRAIN: `mem_req_ready`=0; stay until `mem_req_valid` is sampled 0, then go to IDLE.
  - This guarantees one pulse per request, even if the requester holds valid for an extra cycle.
- Abort: if `mem_req_valid` is sampled 0 in READ or DELAY, set the abort flag.
  - The SRAM sequence still completes, so no partial outstanding reads are left.
  - `mem_req_rdata` is still updated.
- While not in IDLE, `mem_req_addr` changes are ignored.
- `mem_req_rdata` holds its last assembled line until it is overwritten by the next fill.

## Timing
- Reset values: `mem_req_ready`=0, `mem_req_rdata`=0, `sram_en`=0, `sram_addr`=0, `fill_count`=0, state=IDLE. All counters and the abort flag are cleared.
- Reset asserted mid-fill: the next cycle is IDLE with all outputs at reset values. Outstanding SRAM data is discarded.
- Latency: if `mem_req_valid` first goes high in cycle 0 (state IDLE), then:
  - `sram_en` is high in cycles 1..NUM_BLOCKS.
  - The last word is captured at the end of cycle NUM_BLOCKS+1.
  - `mem_req_ready` is high in cycle NUM_BLOCKS+2+EXTRA_LATENCY.
  - With the defaults, `mem_req_ready` is high in cycle 6.
- Back-to-back requests: the earliest next IDLE acceptance is the cycle after valid is sampled low in DRAIN. Minimum request spacing is NUM_BLOCKS+4+EXTRA_LATENCY cycles.
- Valid sampled high in the same cycle that RESP ends: it is ignored, because DRAIN requires valid to be sampled low first.
- `sram_addr` arithmetic is 32-bit. A line at 0xFFFFFFF0 reads 0xFFFFFFF0..0xFFFFFFFC with no wrap past the line.

## Test plan
- Single fill at default parameters: SRAM word at address a = a ^ 0xA5A5A5A5; request addr 0x0000_1234.
  - Required: `sram_addr` 0x1230, 0x1234, 0x1238, 0x123C in cycles 1..4.
  - Required: ready pulse in cycle 6 only, with rdata = {0xA5A5B799, 0xA5A5B79D, 0xA5A5B791, 0xA5A5B795}, word 3 first.
  - Required: `fill_count`=1.
- EXTRA_LATENCY=3, NUM_BLOCKS=8:
  - Required: ready pulse in cycle 13 only.
  - Required: eight sequential word addresses.
- Valid held high 2 cycles past the ready pulse:
  - Required: exactly one pulse.
  - Required: no new SRAM reads until valid is sampled low and then reasserted.
- Valid dropped in cycle 3 of a fill:
  - Required: all 4 SRAM reads still issued.
  - Required: no ready pulse; `fill_count` unchanged.
  - Required: a new request afterwards is served normally.
- `resetn` low in cycle 3 of a fill:
  - Required: next cycle all outputs are 0 and state is IDLE.
  - Required: a subsequent request to 0x40 returns the correct line in cycle 6 after its valid.
- Two back-to-back requests to different lines, each with valid dropped the cycle after its pulse:
  - Required: each line is correct.
  - Required: `fill_count`=2.
  - Required: second acceptance in the cycle after DRAIN sees valid low.

Source files
------------

// File: rtl/imem_line_fill_responder.sv
// Memory-side line-fill responder: reads one cache line a word at a time from a
// synchronous SRAM, assembles it, and returns it with a one-cycle ready pulse.
module imem_line_fill_responder #(
    parameter int NUM_BLOCKS    = 4,
    parameter int BLOCK_SIZE    = 4,
    parameter int EXTRA_LATENCY = 0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_req_valid,
    input  logic [31:0]              mem_req_addr,
    output logic                     mem_req_ready,
    output logic [32*NUM_BLOCKS-1:0] mem_req_rdata,
    output logic                     sram_en,
    output logic [31:0]              sram_addr,
    input  logic [31:0]              sram_rdata,
    output logic [31:0]              fill_count,
    output logic [2:0]               state_dbg
);

    localparam int OFF_BITS = $clog2(NUM_BLOCKS * BLOCK_SIZE);
    localparam int IDX_W    = $clog2(NUM_BLOCKS);
    localparam int CNT_W    = IDX_W + 1;
    localparam int LINE_W   = 32 * NUM_BLOCKS;
    localparam logic [7:0] DLY_LAST = (EXTRA_LATENCY > 0) ? 8'(EXTRA_LATENCY - 1) : 8'd0;

    // state_dbg encoding: 0 IDLE, 1 READ, 2 DELAY, 3 RESP, 4 DRAIN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DELAY = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state;
    logic [31:0]       base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  cap_cnt;
    logic              rd_pend;
    logic              abort_flag;
    logic [7:0]        dly_cnt;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_next;
    logic [31:0]       issue_off;
    logic              abort_next;
    logic              unused_addr_bits;

    assign state_dbg        = state;
    assign unused_addr_bits = ^mem_req_addr[OFF_BITS-1:0];

    // Valid sampled low on the final READ/DELAY cycle must still suppress the pulse.
    always_comb begin
        abort_next = abort_flag | ~mem_req_valid;
        issue_off  = {{(32-CNT_W-2){1'b0}}, issue_cnt, 2'b00};
        line_next  = line_buf;
        line_next[{cap_cnt, 5'b00000} +: 32] = sram_rdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            base          <= 32'd0;
            issue_cnt     <= '0;
            cap_cnt       <= '0;
            rd_pend       <= 1'b0;
            abort_flag    <= 1'b0;
            dly_cnt       <= 8'd0;
            line_buf      <= '0;
            mem_req_ready <= 1'b0;
            mem_req_rdata <= '0;
            sram_en       <= 1'b0;
            sram_addr     <= 32'd0;
            fill_count    <= 32'd0;
        end else begin
            mem_req_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mem_req_valid) begin
                        base       <= {mem_req_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
                        sram_addr  <= {mem_req_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
                        sram_en    <= 1'b1;
                        issue_cnt  <= CNT_W'(1);
                        cap_cnt    <= '0;
                        rd_pend    <= 1'b0;
                        abort_flag <= 1'b0;
                        dly_cnt    <= 8'd0;
                        state      <= S_READ;
                    end
                end
                S_READ: begin
                    abort_flag <= abort_next;
                    rd_pend    <= sram_en;
                    if (issue_cnt != CNT_W'(NUM_BLOCKS)) begin
                        sram_en   <= 1'b1;
                        sram_addr <= base + issue_off;
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end else begin
                        sram_en <= 1'b0;
                    end
                    // Data for the read issued last cycle is on sram_rdata now.
                    if (rd_pend) begin
                        line_buf <= line_next;
                        cap_cnt  <= cap_cnt + IDX_W'(1);
                        if (cap_cnt == IDX_W'(NUM_BLOCKS - 1)) begin
                            mem_req_rdata <= line_next;
                            if (EXTRA_LATENCY > 0) begin
                                state <= S_DELAY;
                            end else begin
                                state         <= S_RESP;
                                mem_req_ready <= ~abort_next;
                                if (!abort_next) fill_count <= fill_count + 32'd1;
                            end
                        end
                    end
                end
                S_DELAY: begin
                    abort_flag <= abort_next;
                    if (dly_cnt == DLY_LAST) begin
                        state         <= S_RESP;
                        mem_req_ready <= ~abort_next;
                        if (!abort_next) fill_count <= fill_count + 32'd1;
                    end else begin
                        dly_cnt <= dly_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!mem_req_valid) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_line_fill_responder.sv
// Self-checking bench for imem_line_fill_responder: default instance (4 words) and a
// long-line instance (8 words, 3 extra wait cycles), each with a behavioural SRAM.
module tb_imem_line_fill_responder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;
    int   gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    // ---------------- DUT A: defaults ----------------
    logic         a_valid, a_ready, a_en;
    logic [31:0]  a_addr, a_saddr, a_fc;
    logic [31:0]  a_srdata = 32'd0;
    logic [127:0] a_rdata;
    logic [2:0]   a_state;

    imem_line_fill_responder dut_a (
        .clk(clk), .resetn(resetn), .mem_req_valid(a_valid), .mem_req_addr(a_addr),
        .mem_req_ready(a_ready), .mem_req_rdata(a_rdata), .sram_en(a_en),
        .sram_addr(a_saddr), .sram_rdata(a_srdata), .fill_count(a_fc), .state_dbg(a_state)
    );

    // ---------------- DUT B: 8 words, 3 extra cycles ----------------
    logic         b_valid, b_ready, b_en;
    logic [31:0]  b_addr, b_saddr, b_fc;
    logic [31:0]  b_srdata = 32'd0;
    logic [255:0] b_rdata;
    logic [2:0]   b_state;

    imem_line_fill_responder #(.NUM_BLOCKS(8), .BLOCK_SIZE(4), .EXTRA_LATENCY(3)) dut_b (
        .clk(clk), .resetn(resetn), .mem_req_valid(b_valid), .mem_req_addr(b_addr),
        .mem_req_ready(b_ready), .mem_req_rdata(b_rdata), .sram_en(b_en),
        .sram_addr(b_saddr), .sram_rdata(b_srdata), .fill_count(b_fc), .state_dbg(b_state)
    );

    // Behavioural SRAMs: word at byte address a is a ^ key, one cycle after the enable.
    logic [31:0] sram_key = 32'hA5A5A5A5;
    always @(posedge clk) if (a_en) a_srdata <= a_saddr ^ sram_key;
    always @(posedge clk) if (b_en) b_srdata <= b_saddr ^ sram_key;

    // ---------------- scoreboard ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    int           exp_fill_a = 0;
    int           exp_fill_b = 0;
    logic [31:0]  exp_q[$];
    logic [31:0]  obs_addr_q[$];
    int           obs_en_cyc_q[$];
    int           obs_rdy_q[$];
    logic [127:0] obs_line_a;
    logic [255:0] obs_line_b;
    logic         timed_out;
    int           obs_start;

    function automatic logic [127:0] line_a(input logic [31:0] addr, input logic [31:0] key);
        logic [127:0] l;
        logic [31:0]  b;
        b = addr & ~32'hF;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = (b + 32'(4*k)) ^ key;
        return l;
    endfunction

    // ---------------- drivers ----------------
    // Drives one request on A starting in the current cycle (just after a posedge).
    // drop_at >= 0: valid goes low in that relative cycle; otherwise valid goes low
    // hold_after cycles after the cycle following the ready pulse.
    task automatic run_fill_a(input logic [31:0] addr, input int drop_at, input int hold_after);
        int cyc;
        int pulse;
        obs_addr_q.delete(); obs_en_cyc_q.delete(); obs_rdy_q.delete();
        timed_out = 1'b0; cyc = 0; pulse = -1; obs_start = gcyc;
        a_valid = 1'b1; a_addr = addr;
        while (1) begin
            @(negedge clk);
            if (a_en) begin obs_addr_q.push_back(a_saddr); obs_en_cyc_q.push_back(cyc); end
            if (a_ready) begin
                obs_rdy_q.push_back(cyc); obs_line_a = a_rdata;
                if (pulse < 0) pulse = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            a_addr = $urandom();
            if (drop_at >= 0 && cyc == drop_at) a_valid = 1'b0;
            if (pulse >= 0 && cyc == pulse + 1 + hold_after) a_valid = 1'b0;
            if (a_state == 3'd0) break;
            if (cyc > 60) begin timed_out = 1'b1; a_valid = 1'b0; break; end
        end
    endtask

    task automatic run_fill_b(input logic [31:0] addr);
        int cyc;
        int pulse;
        obs_addr_q.delete(); obs_en_cyc_q.delete(); obs_rdy_q.delete();
        timed_out = 1'b0; cyc = 0; pulse = -1;
        b_valid = 1'b1; b_addr = addr;
        while (1) begin
            @(negedge clk);
            if (b_en) begin obs_addr_q.push_back(b_saddr); obs_en_cyc_q.push_back(cyc); end
            if (b_ready) begin
                obs_rdy_q.push_back(cyc); obs_line_b = b_rdata;
                if (pulse < 0) pulse = cyc;
            end
            @(posedge clk); #1;
            cyc++;
            b_addr = $urandom();
            if (pulse >= 0 && cyc == pulse + 1) b_valid = 1'b0;
            if (b_state == 3'd0) break;
            if (cyc > 80) begin timed_out = 1'b1; b_valid = 1'b0; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0; a_valid = 1'b0; a_addr = 32'd0; b_valid = 1'b0; b_addr = 32'd0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", a_ready); end
        n_cmp++; if (a_rdata !== 128'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
        n_cmp++; if (a_en !== 1'b0) begin n_bad++; $display("FAIL reset_sram_en: got %b want 0", a_en); end
        n_cmp++; if (a_saddr !== 32'd0) begin n_bad++; $display("FAIL reset_sram_addr: got %h want 0", a_saddr); end
        n_cmp++; if (a_fc !== 32'd0) begin n_bad++; $display("FAIL reset_fill_count: got %0d want 0", a_fc); end
        n_cmp++; if (a_state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", a_state); end
        n_cmp++; if (b_rdata !== 256'd0) begin n_bad++; $display("FAIL reset_b_rdata: got %h want 0", b_rdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_fill();
        sram_key = 32'hA5A5A5A5;
        run_fill_a(32'h0000_1234, -1, 0);
        exp_fill_a++;
        exp_q = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL single_timeout: got %b want 0", timed_out); end
        n_cmp++; if (obs_addr_q.size() != 4) begin n_bad++; $display("FAIL single_nreads: got %0d want 4", obs_addr_q.size()); end
        for (int k = 0; k < obs_addr_q.size() && exp_q.size() > 0; k++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_cmp++; if (obs_addr_q[k] !== e) begin n_bad++; $display("FAIL single_addr%0d: got %h want %h", k, obs_addr_q[k], e); end
            n_cmp++; if (obs_en_cyc_q[k] != k + 1) begin n_bad++; $display("FAIL single_en_cyc%0d: got %0d want %0d", k, obs_en_cyc_q[k], k + 1); end
        end
        n_cmp++; if (obs_rdy_q.size() != 1) begin n_bad++; $display("FAIL single_npulse: got %0d want 1", obs_rdy_q.size()); end
        n_cmp++; if (obs_rdy_q.size() > 0 && obs_rdy_q[0] != 6) begin n_bad++; $display("FAIL single_pulse_cyc: got %0d want 6", obs_rdy_q[0]); end
        n_cmp++; if (obs_line_a !== 128'hA5A5B799_A5A5B79D_A5A5B791_A5A5B795) begin
            n_bad++; $display("FAIL single_line: got %h want A5A5B799A5A5B79DA5A5B791A5A5B795", obs_line_a); end
        n_cmp++; if (a_fc !== 32'd1) begin n_bad++; $display("FAIL single_fill_count: got %0d want 1", a_fc); end
    endtask

    task automatic test_long_line();
        logic [255:0] exp_line;
        logic [31:0]  addr;
        logic [31:0]  base;
        addr = 32'h0008_7A5C; base = addr & ~32'h1F;
        sram_key = $urandom();
        run_fill_b(addr);
        exp_fill_b++;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(base + 32'(4*k));
            exp_line[32*k +: 32] = (base + 32'(4*k)) ^ sram_key;
        end
        n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL long_timeout: got %b want 0", timed_out); end
        n_cmp++; if (obs_addr_q.size() != 8) begin n_bad++; $display("FAIL long_nreads: got %0d want 8", obs_addr_q.size()); end
        for (int k = 0; k < obs_addr_q.size() && exp_q.size() > 0; k++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            n_cmp++; if (obs_addr_q[k] !== e) begin n_bad++; $display("FAIL long_addr%0d: got %h want %h", k, obs_addr_q[k], e); end
        end
        n_cmp++; if (obs_rdy_q.size() != 1) begin n_bad++; $display("FAIL long_npulse: got %0d want 1", obs_rdy_q.size()); end
        n_cmp++; if (obs_rdy_q.size() > 0 && obs_rdy_q[0] != 13) begin n_bad++; $display("FAIL long_pulse_cyc: got %0d want 13", obs_rdy_q[0]); end
        n_cmp++; if (obs_line_b !== exp_line) begin n_bad++; $display("FAIL long_line: got %h want %h", obs_line_b, exp_line); end
        n_cmp++; if (b_fc !== 32'(exp_fill_b)) begin n_bad++; $display("FAIL long_fill_count: got %0d want %0d", b_fc, exp_fill_b); end
    endtask

    task automatic test_hold_valid();
        sram_key = $urandom();
        run_fill_a(32'h0000_2000, -1, 2);
        exp_fill_a++;
        n_cmp++; if (obs_rdy_q.size() != 1) begin n_bad++; $display("FAIL hold_npulse: got %0d want 1", obs_rdy_q.size()); end
        n_cmp++; if (obs_addr_q.size() != 4) begin n_bad++; $display("FAIL hold_nreads: got %0d want 4", obs_addr_q.size()); end
        n_cmp++; if (obs_line_a !== line_a(32'h2000, sram_key)) begin n_bad++; $display("FAIL hold_line: got %h want %h", obs_line_a, line_a(32'h2000, sram_key)); end
        n_cmp++; if (a_fc !== 32'(exp_fill_a)) begin n_bad++; $display("FAIL hold_fill_count: got %0d want %0d", a_fc, exp_fill_a); end
        @(posedge clk); #1;
        run_fill_a(32'h0000_2010, -1, 0);
        exp_fill_a++;
        n_cmp++; if (obs_rdy_q.size() != 1 || obs_rdy_q[0] != 6) begin n_bad++; $display("FAIL hold_next_pulse: got %0d pulses want 1 at cycle 6", obs_rdy_q.size()); end
    endtask

    task automatic test_abort();
        sram_key = $urandom();
        run_fill_a(32'h0000_3004, 3, 0);
        n_cmp++; if (obs_addr_q.size() != 4) begin n_bad++; $display("FAIL abort_nreads: got %0d want 4", obs_addr_q.size()); end
        n_cmp++; if (obs_rdy_q.size() != 0) begin n_bad++; $display("FAIL abort_npulse: got %0d want 0", obs_rdy_q.size()); end
        n_cmp++; if (a_fc !== 32'(exp_fill_a)) begin n_bad++; $display("FAIL abort_fill_count: got %0d want %0d", a_fc, exp_fill_a); end
        n_cmp++; if (a_rdata !== line_a(32'h3004, sram_key)) begin n_bad++; $display("FAIL abort_rdata: got %h want %h", a_rdata, line_a(32'h3004, sram_key)); end
        run_fill_a(32'h0000_3100, -1, 0);
        exp_fill_a++;
        n_cmp++; if (obs_rdy_q.size() != 1 || obs_rdy_q[0] != 6) begin n_bad++; $display("FAIL abort_next_pulse: got %0d pulses want 1 at cycle 6", obs_rdy_q.size()); end
        n_cmp++; if (obs_line_a !== line_a(32'h3100, sram_key)) begin n_bad++; $display("FAIL abort_next_line: got %h want %h", obs_line_a, line_a(32'h3100, sram_key)); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] line1;
        int           start1;
        int           npulse1;
        int           fc0;
        logic [31:0]  ad1;
        logic [31:0]  ad2;
        ad1 = $urandom(); ad2 = ad1 ^ 32'h0001_0040;
        sram_key = $urandom();
        fc0 = exp_fill_a;
        run_fill_a(ad1, -1, 0);
        exp_fill_a++;
        line1 = obs_line_a; start1 = obs_start; npulse1 = obs_rdy_q.size();
        run_fill_a(ad2, -1, 0);
        exp_fill_a++;
        n_cmp++; if (npulse1 != 1) begin n_bad++; $display("FAIL b2b_npulse1: got %0d want 1", npulse1); end
        n_cmp++; if (line1 !== line_a(ad1, sram_key)) begin n_bad++; $display("FAIL b2b_line1: got %h want %h", line1, line_a(ad1, sram_key)); end
        n_cmp++; if (obs_line_a !== line_a(ad2, sram_key)) begin n_bad++; $display("FAIL b2b_line2: got %h want %h", obs_line_a, line_a(ad2, sram_key)); end
        n_cmp++; if (obs_rdy_q.size() != 1 || obs_rdy_q[0] != 6) begin n_bad++; $display("FAIL b2b_pulse2: got %0d pulses want 1 at cycle 6", obs_rdy_q.size()); end
        n_cmp++; if (obs_start - start1 != 8) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 8", obs_start - start1); end
        n_cmp++; if (a_fc !== 32'(fc0 + 2)) begin n_bad++; $display("FAIL b2b_fill_count: got %0d want %0d", a_fc, fc0 + 2); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [31:0] addr;
            logic [31:0] base;
            int          mode;
            int          drop;
            addr = (it == 0) ? 32'hFFFF_FFF4 : $urandom();
            base = addr & ~32'hF;
            sram_key = $urandom();
            mode = $urandom_range(0, 2);
            drop = (mode == 0) ? $urandom_range(1, 5) : -1;
            run_fill_a(addr, drop, $urandom_range(0, 3));
            if (mode != 0) exp_fill_a++;
            exp_q.delete();
            for (int k = 0; k < 4; k++) exp_q.push_back(base + 32'(4*k));
            n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_timeout: got %b want 0", it, timed_out); end
            n_cmp++; if (obs_addr_q.size() != 4) begin n_bad++; $display("FAIL rnd%0d_nreads: got %0d want 4", it, obs_addr_q.size()); end
            for (int k = 0; k < obs_addr_q.size() && exp_q.size() > 0; k++) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                n_cmp++; if (obs_addr_q[k] !== e) begin n_bad++; $display("FAIL rnd%0d_addr%0d: got %h want %h", it, k, obs_addr_q[k], e); end
                n_cmp++; if (obs_en_cyc_q[k] != k + 1) begin n_bad++; $display("FAIL rnd%0d_en_cyc%0d: got %0d want %0d", it, k, obs_en_cyc_q[k], k + 1); end
            end
            n_cmp++; if (obs_rdy_q.size() != ((mode == 0) ? 0 : 1)) begin n_bad++; $display("FAIL rnd%0d_npulse: got %0d want %0d", it, obs_rdy_q.size(), (mode == 0) ? 0 : 1); end
            if (mode != 0 && obs_rdy_q.size() > 0) begin
                n_cmp++; if (obs_rdy_q[0] != 6) begin n_bad++; $display("FAIL rnd%0d_pulse_cyc: got %0d want 6", it, obs_rdy_q[0]); end
            end
            n_cmp++; if (a_rdata !== line_a(addr, sram_key)) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", it, a_rdata, line_a(addr, sram_key)); end
            n_cmp++; if (a_fc !== 32'(exp_fill_a)) begin n_bad++; $display("FAIL rnd%0d_fill_count: got %0d want %0d", it, a_fc, exp_fill_a); end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid_fill();
        sram_key = $urandom();
        a_valid = 1'b1; a_addr = 32'h0000_5678;
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1; a_valid = 1'b0;
        exp_fill_a = 0; exp_fill_b = 0;
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", a_ready); end
        n_cmp++; if (a_rdata !== 128'd0) begin n_bad++; $display("FAIL midrst_rdata: got %h want 0", a_rdata); end
        n_cmp++; if (a_en !== 1'b0) begin n_bad++; $display("FAIL midrst_sram_en: got %b want 0", a_en); end
        n_cmp++; if (a_saddr !== 32'd0) begin n_bad++; $display("FAIL midrst_sram_addr: got %h want 0", a_saddr); end
        n_cmp++; if (a_fc !== 32'd0) begin n_bad++; $display("FAIL midrst_fill_count: got %0d want 0", a_fc); end
        n_cmp++; if (a_state !== 3'd0) begin n_bad++; $display("FAIL midrst_state: got %0d want 0", a_state); end
        n_cmp++; if (b_fc !== 32'd0) begin n_bad++; $display("FAIL midrst_b_fill_count: got %0d want 0", b_fc); end
        @(posedge clk); #1;
        run_fill_a(32'h0000_0040, -1, 0);
        exp_fill_a++;
        n_cmp++; if (obs_rdy_q.size() != 1 || obs_rdy_q[0] != 6) begin n_bad++; $display("FAIL midrst_next_pulse: got %0d pulses want 1 at cycle 6", obs_rdy_q.size()); end
        n_cmp++; if (obs_line_a !== line_a(32'h40, sram_key)) begin n_bad++; $display("FAIL midrst_next_line: got %h want %h", obs_line_a, line_a(32'h40, sram_key)); end
        n_cmp++; if (a_fc !== 32'(exp_fill_a)) begin n_bad++; $display("FAIL midrst_next_fill_count: got %0d want %0d", a_fc, exp_fill_a); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_fill();
        test_long_line();
        test_hold_valid();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
